// File: rtl/rgb_pwm_sequencer.sv
// rtl/rgb_pwm_sequencer.sv - RGB LED PWM sequencer with static, cycle, fade and breathe modes
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   enable       1 = run, 0 = freeze all counters and duties, outputs forced low
//   mode         0 STATIC, 1 CYCLE, 2 FADE, 3 BREATHE (takes effect at a period boundary)
//   color_sel    channel mask {blue, green, red} for STATIC and BREATHE, sampled at a boundary
//   red/green/blue  active-high PWM outputs, one cycle behind the PWM counter
//   period_start one-cycle pulse following each PWM period boundary
//   phase        current sequencer phase
module rgb_pwm_sequencer #(
    parameter int PWM_WIDTH    = 8,
    parameter int PRESCALE     = 1,
    parameter int STEP_PERIODS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [1:0] mode,
    input  logic [2:0] color_sel,
    output logic       red,
    output logic       green,
    output logic       blue,
    output logic       period_start,
    output logic [1:0] phase
);

    localparam int PRE_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int STEP_W = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;

    localparam logic [PRE_W-1:0]     PRE_LAST  = PRE_W'(PRESCALE - 1);
    localparam logic [STEP_W-1:0]    STEP_LAST = STEP_W'(STEP_PERIODS - 1);
    localparam logic [PWM_WIDTH-1:0] MAX_V     = '1;

    typedef enum logic [1:0] {
        MODE_STATIC  = 2'd0,
        MODE_CYCLE   = 2'd1,
        MODE_FADE    = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_e;

    mode_e                mode_in;
    mode_e                mode_q, mode_d;
    logic [PRE_W-1:0]     pre_cnt_q, pre_cnt_d;
    logic [PWM_WIDTH-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [STEP_W-1:0]    step_cnt_q, step_cnt_d;
    logic [PWM_WIDTH-1:0] lvl_q, lvl_d;
    logic [1:0]           phase_q, phase_d;
    logic [PWM_WIDTH-1:0] duty_r_q, duty_r_d;
    logic [PWM_WIDTH-1:0] duty_g_q, duty_g_d;
    logic [PWM_WIDTH-1:0] duty_b_q, duty_b_d;
    logic                 red_q, red_d;
    logic                 green_q, green_d;
    logic                 blue_q, blue_d;
    logic                 period_start_q, period_start_d;

    logic                 tick;
    logic                 boundary;
    logic                 mode_change;
    logic [PWM_WIDTH-1:0] src_lvl;
    logic [1:0]           src_phase;
    logic [PWM_WIDTH-1:0] calc_r, calc_g, calc_b;
    logic [PWM_WIDTH-1:0] eff_r, eff_g, eff_b;
    logic [PWM_WIDTH-1:0] breathe_duty;

    assign mode_in = mode_e'(mode);

    // Timebase: prescaler, PWM counter and period boundary detection.
    always_comb begin
        tick      = enable && (pre_cnt_q == PRE_LAST);
        boundary  = enable && (pre_cnt_q == '0) && (pwm_cnt_q == '0);
        pre_cnt_d = pre_cnt_q;
        pwm_cnt_d = pwm_cnt_q;
        if (enable) begin
            pre_cnt_d = tick ? '0 : pre_cnt_q + 1'b1;
        end
        if (tick) begin
            pwm_cnt_d = pwm_cnt_q + 1'b1;
        end
    end

    // A mode switch restarts the pattern, so the duties loaded at that
    // boundary come from level 0 / phase 0 rather than the stale sequencer state.
    always_comb begin
        mode_change = (mode_in != mode_q);
        src_lvl     = mode_change ? '0 : lvl_q;
        src_phase   = mode_change ? 2'd0 : phase_q;
    end

    // Duty table, evaluated against the incoming mode: at a boundary it is
    // either equal to the latched mode or the pattern has just been restarted.
    always_comb begin
        calc_r       = '0;
        calc_g       = '0;
        calc_b       = '0;
        breathe_duty = (src_phase == 2'd1) ? (MAX_V - src_lvl) : src_lvl;
        case (mode_in)
            MODE_STATIC: begin
                calc_r = color_sel[0] ? MAX_V : '0;
                calc_g = color_sel[1] ? MAX_V : '0;
                calc_b = color_sel[2] ? MAX_V : '0;
            end
            MODE_CYCLE: begin
                calc_r = (src_phase == 2'd0) ? MAX_V : '0;
                calc_g = (src_phase == 2'd1) ? MAX_V : '0;
                calc_b = (src_phase == 2'd2) ? MAX_V : '0;
            end
            MODE_FADE: begin
                case (src_phase)
                    2'd0: begin
                        calc_r = MAX_V - src_lvl;
                        calc_g = src_lvl;
                    end
                    2'd1: begin
                        calc_g = MAX_V - src_lvl;
                        calc_b = src_lvl;
                    end
                    2'd2: begin
                        calc_b = MAX_V - src_lvl;
                        calc_r = src_lvl;
                    end
                    default: begin
                        calc_r = '0;
                    end
                endcase
            end
            MODE_BREATHE: begin
                // Phase 2 is unreachable here; it falls through to the ramp-up shape.
                calc_r = color_sel[0] ? breathe_duty : '0;
                calc_g = color_sel[1] ? breathe_duty : '0;
                calc_b = color_sel[2] ? breathe_duty : '0;
            end
            default: begin
                calc_r = '0;
            end
        endcase
    end

    // Sequencer state: latched mode, step/level/phase progression and duty registers.
    always_comb begin
        mode_d     = mode_q;
        step_cnt_d = step_cnt_q;
        lvl_d      = lvl_q;
        phase_d    = phase_q;
        duty_r_d   = duty_r_q;
        duty_g_d   = duty_g_q;
        duty_b_d   = duty_b_q;
        if (boundary) begin
            mode_d   = mode_in;
            duty_r_d = calc_r;
            duty_g_d = calc_g;
            duty_b_d = calc_b;
            if (mode_change) begin
                step_cnt_d = '0;
                lvl_d      = '0;
                phase_d    = 2'd0;
            end else begin
                step_cnt_d = (step_cnt_q == STEP_LAST) ? '0 : step_cnt_q + 1'b1;
                if (step_cnt_q == STEP_LAST) begin
                    if (mode_q == MODE_STATIC) begin
                        lvl_d   = '0;
                        phase_d = 2'd0;
                    end else begin
                        lvl_d = lvl_q + 1'b1;
                        if (lvl_q == MAX_V) begin
                            case (mode_q)
                                MODE_CYCLE, MODE_FADE:
                                    phase_d = (phase_q >= 2'd2) ? 2'd0 : phase_q + 2'd1;
                                MODE_BREATHE:
                                    phase_d = (phase_q == 2'd0) ? 2'd1 : 2'd0;
                                default:
                                    phase_d = 2'd0;
                            endcase
                        end
                    end
                end
            end
        end
    end

    // Output comparators use the freshly loaded duty on the boundary cycle
    // so a new period never shows the previous period's duty.
    always_comb begin
        eff_r          = boundary ? calc_r : duty_r_q;
        eff_g          = boundary ? calc_g : duty_g_q;
        eff_b          = boundary ? calc_b : duty_b_q;
        red_d          = enable && (pwm_cnt_q < eff_r);
        green_d        = enable && (pwm_cnt_q < eff_g);
        blue_d         = enable && (pwm_cnt_q < eff_b);
        period_start_d = boundary;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q         <= MODE_STATIC;
            pre_cnt_q      <= '0;
            pwm_cnt_q      <= '0;
            step_cnt_q     <= '0;
            lvl_q          <= '0;
            phase_q        <= 2'd0;
            duty_r_q       <= '0;
            duty_g_q       <= '0;
            duty_b_q       <= '0;
            red_q          <= 1'b0;
            green_q        <= 1'b0;
            blue_q         <= 1'b0;
            period_start_q <= 1'b0;
        end else begin
            mode_q         <= mode_d;
            pre_cnt_q      <= pre_cnt_d;
            pwm_cnt_q      <= pwm_cnt_d;
            step_cnt_q     <= step_cnt_d;
            lvl_q          <= lvl_d;
            phase_q        <= phase_d;
            duty_r_q       <= duty_r_d;
            duty_g_q       <= duty_g_d;
            duty_b_q       <= duty_b_d;
            red_q          <= red_d;
            green_q        <= green_d;
            blue_q         <= blue_d;
            period_start_q <= period_start_d;
        end
    end

    assign red          = red_q;
    assign green        = green_q;
    assign blue         = blue_q;
    assign period_start = period_start_q;
    assign phase        = phase_q;

endmodule

// File: tb/tb_rgb_pwm_sequencer.sv
// tb/tb_rgb_pwm_sequencer.sv - randomized scoreboard bench for rgb_pwm_sequencer
module tb_rgb_pwm_sequencer;

    localparam int W    = 3;
    localparam int P    = 2;
    localparam int S    = 2;
    localparam int M2   = 1 << W;
    localparam int MAXV = M2 - 1;
    localparam int NCYC = 40000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [2:0] color_sel = 3'd0;
    logic       red, green, blue, period_start;
    logic [1:0] phase;

    logic [5:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    // Reference model state, in terms of elapsed enabled cycles and periods.
    int e_cnt  = 0;   // enabled cycles since reset
    int n_per  = 0;   // periods counted since the current mode was latched
    int lmode  = 0;   // latched mode
    int dr = 0, dg = 0, db = 0;

    rgb_pwm_sequencer #(
        .PWM_WIDTH   (W),
        .PRESCALE    (P),
        .STEP_PERIODS(S)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .mode        (mode),
        .color_sel   (color_sel),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .period_start(period_start),
        .phase       (phase)
    );

    always #5 clk = ~clk;

    function automatic int num_phases(input int m);
        case (m)
            0:       return 1;
            3:       return 2;
            default: return 3;
        endcase
    endfunction

    function automatic int level_of(input int n);
        return (n / S) % M2;
    endfunction

    function automatic int phase_of(input int n, input int m);
        return ((n / S) / M2) % num_phases(m);
    endfunction

    task automatic pattern(input int n, input int m, input logic [2:0] s,
                           output int r, output int g, output int b);
        int lv, ph, d;
        lv = level_of(n);
        ph = phase_of(n, m);
        r = 0; g = 0; b = 0;
        case (m)
            0: begin
                r = s[0] ? MAXV : 0;
                g = s[1] ? MAXV : 0;
                b = s[2] ? MAXV : 0;
            end
            1: begin
                if (ph == 0) r = MAXV;
                if (ph == 1) g = MAXV;
                if (ph == 2) b = MAXV;
            end
            2: begin
                if (ph == 0) begin r = MAXV - lv; g = lv; end
                if (ph == 1) begin g = MAXV - lv; b = lv; end
                if (ph == 2) begin b = MAXV - lv; r = lv; end
            end
            default: begin
                d = (ph == 0) ? lv : MAXV - lv;
                r = s[0] ? d : 0;
                g = s[1] ? d : 0;
                b = s[2] ? d : 0;
            end
        endcase
    endtask

    // Advance the model by one clock using the inputs now applied; returns
    // the expected {red, green, blue, period_start, phase} after the edge.
    task automatic model_step(output logic [5:0] exp_v);
        int  pwm;
        bit  at_b;
        logic r, g, b;
        if (reset) begin
            e_cnt = 0; n_per = 0; lmode = 0;
            dr = 0; dg = 0; db = 0;
            exp_v = 6'b0;
        end else if (!enable) begin
            exp_v = {4'b0000, 2'(phase_of(n_per, lmode))};
        end else begin
            pwm  = (e_cnt / P) % M2;
            at_b = (e_cnt % (P * M2)) == 0;
            if (at_b) begin
                if (int'(mode) != lmode) begin
                    lmode = int'(mode);
                    n_per = 0;
                    pattern(0, lmode, color_sel, dr, dg, db);
                end else begin
                    pattern(n_per, lmode, color_sel, dr, dg, db);
                    n_per++;
                end
            end
            r = pwm < dr;
            g = pwm < dg;
            b = pwm < db;
            e_cnt++;
            exp_v = {r, g, b, at_b, 2'(phase_of(n_per, lmode))};
        end
    endtask

    // Monitor: compares each DUT response against the queued expectation.
    initial begin
        logic [5:0] ev;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                ev = exp_q.pop_front();
                checks++;
                if ({red, green, blue} !== ev[5:3]) begin
                    errors++;
                    $display("FAIL rgb t=%0t got=%b exp=%b", $time, {red, green, blue}, ev[5:3]);
                end
                checks++;
                if (period_start !== ev[2]) begin
                    errors++;
                    $display("FAIL period_start t=%0t got=%b exp=%b", $time, period_start, ev[2]);
                end
                checks++;
                if (phase !== ev[1:0]) begin
                    errors++;
                    $display("FAIL phase t=%0t got=%0d exp=%0d", $time, phase, ev[1:0]);
                end
            end
        end
    end

    // Stimulus: random mode/colour changes, enable gaps and occasional resets.
    initial begin
        logic [5:0] ev;
        int dis_left;
        int wait_cyc;
        dis_left = 0;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            if (cyc < 3) begin
                reset = 1'b1;
                enable = 1'b0;
                mode = 2'd0;
                color_sel = 3'b001;
            end else begin
                reset = ($urandom_range(0, 2999) == 0);
                if (dis_left > 0) begin
                    enable = 1'b0;
                    dis_left--;
                end else if ($urandom_range(0, 149) == 0) begin
                    enable = 1'b0;
                    dis_left = $urandom_range(1, 12);
                end else begin
                    enable = 1'b1;
                end
                if ($urandom_range(0, 899) == 0) mode = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 59) == 0) color_sel = 3'($urandom_range(0, 7));
            end
            model_step(ev);
            exp_q.push_back(ev);
        end
        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        #2;
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending=%0d exp=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rgb_pwm_sequencer.md
Name: rgb_pwm_sequencer

Overview:
Parametrised successor to the single-pattern RGB LED controller. Drives one RGB LED through PWM with selectable resolution, prescaling and step rate. Four run-time modes: static colour, discrete R/G/B cycle, smooth hue-wheel fade, and breathing. Sits between the board clock/reset and the LED pins; top-level mode and colour select come from switches or a register.

Parameters:
PWM_WIDTH, 8, duty/counter resolution; PWM period = 2^PWM_WIDTH ticks; MAX = 2^PWM_WIDTH-1
PRESCALE, 1, clk cycles per PWM tick (>=1)
STEP_PERIODS, 4, PWM periods per level step (>=1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
enable  in  1  run/freeze
mode  in  2  0 STATIC, 1 CYCLE, 2 FADE, 3 BREATHE
color_sel  in  3  bit0 red, bit1 green, bit2 blue (STATIC/BREATHE)
red  out  1  PWM output, active-high
green  out  1  PWM output
blue  out  1  PWM output
period_start  out  1  one-cycle pulse at each PWM period boundary
phase  out  2  current sequencer phase

Behaviour:
- One clock; reset is synchronous and active-high. At reset: all counters, duties, phase, latched mode, red/green/blue and period_start are 0.
- pre_cnt counts 0..PRESCALE-1 while enable=1. tick = enable & (pre_cnt==PRESCALE-1).
- pwm_cnt (PWM_WIDTH bits) increments on tick and wraps MAX->0.
- Boundary B = enable & pre_cnt==0 & pwm_cnt==0. B is true on the first enabled cycle after reset.
- period_start is registered and equals B delayed one cycle.
- At B:
  - mode is latched, i.e. mode changes take effect only at boundaries.
  - If the latched mode differs from the new mode: lvl, phase and step_cnt clear to 0, and duties are computed from the cleared values.
  - Otherwise duty_r/g/b load from the current lvl/phase. Then step_cnt increments, wrapping at STEP_PERIODS-1. On that wrap lvl increments, and on lvl wrap (MAX->0) the phase advances.
- Duty rules per mode, with s=color_sel:
  - STATIC: duty_x = s[x] ? MAX : 0. lvl and phase are held at 0.
  - CYCLE: phase 0,1,2 = red, green, blue. The active channel duty is MAX, others 0. phase 2 -> 0.
  - FADE: phase 0: r=MAX-lvl, g=lvl, b=0. phase 1: g=MAX-lvl, b=lvl, r=0. phase 2: b=MAX-lvl, r=lvl, g=0. phase 2 -> 0.
  - BREATHE: phase 0 (up) duty=lvl; phase 1 (down) duty=MAX-lvl, for channels with s[x]=1, others 0. phase 1 -> 0. Phase 2 is never entered; if reached it forces phase 0.
- Output: each enabled clock, x <= (pwm_cnt < duty_eff_x). duty_eff is the value being loaded if B, else the duty register.
  - One-cycle latency from pwm_cnt.
  - duty 0 means always 0; duty MAX means high for MAX of 2^PWM_WIDTH ticks.
- enable=0:
  - pre_cnt, pwm_cnt, step_cnt, lvl, phase and duties freeze.
  - red/green/blue/period_start go 0 on the next edge.
  - On re-enable the block resumes from the frozen counts.
- Reset mid-operation: on the next edge everything returns to the reset values, regardless of enable or mode.
- color_sel is sampled only at B.

Test Plan:
- W=8, P=1, S=4, enable=1, mode=0, s=001 after reset -> period_start at cycle 1. red is 1 for 255 cycles, then 0 for 1 cycle, repeating. green=blue=0.
- W=2, P=1, S=1, mode=1 -> red high 3 of 4 clocks for 16 clocks, then green, then blue, then red. phase steps 0,1,2,0 every 16 clocks.
- W=2, P=1, S=1, mode=2 -> red duty sequence 3,2,1,0 and green 0,1,2,3, one value per 4-clock period. Then phase 1. Period-average duties always sum to 3.
- W=2, P=2, S=1, mode=3, s=101 -> red and blue duties 0,1,2,3,3,2,1,0 per 8-clock period. green stays 0. period_start every 8 clocks.
- Mode 0->2 written mid-period -> no duty change until the next period_start. Then lvl=0, phase=0, red=MAX.
- enable low for 10 cycles mid-period -> outputs go 0. After re-enable, pwm_cnt continues from its frozen value. Reset asserted during fade -> all outputs 0 on the next edge.
